// File: rtl/perf_counter_bank.sv
// ---------------------------------------------------------------------------
// perf_counter_bank
//
// Performance counter bank that sits beside the pipeline. It holds:
//   - one "total" counter that counts cycles/instructions and adds exactly
//     one count for each stall run, however long the run is;
//   - N_CH generic event counters. Each one counts either high cycles or
//     rising edges of its strobe;
//   - a shadow bank that captures all live counters atomically, and a
//     registered select port that reads the shadow bank back.
// When a counter overflows it either wraps or saturates, depending on SAT.
// Each counter has a sticky overflow flag.
//
// Ports:
//   in_CLK          clock; all state updates on the rising edge
//   in_RST          synchronous, active-high reset
//   in_EN           pipeline enable (low = stalled)
//   in_EV           event strobes; bit i feeds channel i
//   in_CLR          clears live counters, stall flag and overflow flags
//   in_FREEZE       holds live counters, stall flag and overflow flags
//   in_SNAP         copies live counters into the shadow bank
//   in_SEL          readout select: 0 = total, k = channel k-1
//   out_total       live total counter
//   out_ev          live channel counters; channel i at [i*WIDTH +: WIDTH]
//   out_rd_data     shadow value picked by in_SEL, one cycle of latency
//   out_snap_valid  pulses in the cycle after a snapshot
//   out_ovf         sticky overflow flags; bit 0 = total, bit i+1 = channel i
// ---------------------------------------------------------------------------
module perf_counter_bank #(
  parameter int              N_CH      = 3,
  parameter int              WIDTH     = 32,
  parameter int              SAT       = 0,
  parameter logic [N_CH-1:0] EDGE_MASK = '0
) (
  input  logic                  in_CLK,
  input  logic                  in_RST,
  input  logic                  in_EN,
  input  logic [N_CH-1:0]       in_EV,
  input  logic                  in_CLR,
  input  logic                  in_FREEZE,
  input  logic                  in_SNAP,
  input  logic [4:0]            in_SEL,
  output logic [WIDTH-1:0]      out_total,
  output logic [N_CH*WIDTH-1:0] out_ev,
  output logic [WIDTH-1:0]      out_rd_data,
  output logic                  out_snap_valid,
  output logic [N_CH:0]         out_ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] total_q, total_d;
  logic             flag_q, flag_d;
  logic [WIDTH-1:0] ev_cnt_q [N_CH];
  logic [WIDTH-1:0] ev_cnt_d [N_CH];
  logic [N_CH-1:0]  ev_hist_q, ev_hist_d;
  logic [N_CH:0]    ovf_q, ovf_d;
  logic [WIDTH-1:0] shadow_total_q, shadow_total_d;
  logic [WIDTH-1:0] shadow_ev_q [N_CH];
  logic [WIDTH-1:0] shadow_ev_d [N_CH];
  logic             snap_valid_q, snap_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  // Increment one counter by one step.
  // The MSB of the result reports that the counter was already at its
  // maximum. The low bits are the new value, which is either wrapped to 0
  // or held at max, depending on SAT.
  function automatic logic [WIDTH:0] bump(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] r;
    if (v == CNT_MAX) begin
      r = {1'b1, (SAT != 0) ? CNT_MAX : '0};
    end else begin
      r = {1'b0, v + CNT_ONE};
    end
    return r;
  endfunction

  // Next state of the live counters, the stall flag and the overflow flags.
  // Clear wins over freeze. The edge history always follows the input, even
  // during a freeze, so that an edge-mode strobe held high across a freeze
  // does not gain a count when the freeze is released.
  always_comb begin
    logic [WIDTH:0] b;
    total_d   = total_q;
    flag_d    = flag_q;
    ev_cnt_d  = ev_cnt_q;
    ovf_d     = ovf_q;
    ev_hist_d = in_EV;
    b         = '0;
    if (in_CLR) begin
      total_d  = '0;
      flag_d   = 1'b0;
      ev_cnt_d = '{default: '0};
      ovf_d    = '0;
    end else if (!in_FREEZE) begin
      // The first cycle of a stall run counts. The remaining stall cycles
      // are absorbed by the flag.
      if (in_EN || !flag_q) begin
        b        = bump(total_q);
        total_d  = b[WIDTH-1:0];
        ovf_d[0] = ovf_q[0] | b[WIDTH];
      end
      flag_d = !in_EN;
      for (int i = 0; i < N_CH; i++) begin
        if (in_EV[i] && (!EDGE_MASK[i] || !ev_hist_q[i])) begin
          b          = bump(ev_cnt_q[i]);
          ev_cnt_d[i] = b[WIDTH-1:0];
          ovf_d[i+1] = ovf_q[i+1] | b[WIDTH];
        end
      end
    end
  end

  // Shadow capture and readout select.
  // The shadow bank takes the live values as registered before this edge's
  // update, so a snapshot combined with a clear still captures the values
  // from before the clear. The readout uses the shadow value of the same
  // edge, so a snapshot and a select in one cycle return the new snapshot.
  always_comb begin
    shadow_total_d = shadow_total_q;
    shadow_ev_d    = shadow_ev_q;
    if (in_SNAP) begin
      shadow_total_d = total_q;
      shadow_ev_d    = ev_cnt_q;
    end
    snap_valid_d = in_SNAP;
    rd_data_d    = '0;
    if (in_SEL == 5'd0) begin
      rd_data_d = shadow_total_d;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (in_SEL == 5'(i + 1)) begin
        rd_data_d = shadow_ev_d[i];
      end
    end
  end

  // All state registers. The reset is synchronous.
  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      total_q        <= '0;
      flag_q         <= 1'b0;
      ev_cnt_q       <= '{default: '0};
      ev_hist_q      <= '0;
      ovf_q          <= '0;
      shadow_total_q <= '0;
      shadow_ev_q    <= '{default: '0};
      snap_valid_q   <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      total_q        <= total_d;
      flag_q         <= flag_d;
      ev_cnt_q       <= ev_cnt_d;
      ev_hist_q      <= ev_hist_d;
      ovf_q          <= ovf_d;
      shadow_total_q <= shadow_total_d;
      shadow_ev_q    <= shadow_ev_d;
      snap_valid_q   <= snap_valid_d;
      rd_data_q      <= rd_data_d;
    end
  end

  // Drive the outputs straight from the registers.
  always_comb begin
    out_ev = '0;
    for (int i = 0; i < N_CH; i++) begin
      out_ev[i*WIDTH +: WIDTH] = ev_cnt_q[i];
    end
  end

  assign out_total      = total_q;
  assign out_rd_data    = rd_data_q;
  assign out_snap_valid = snap_valid_q;
  assign out_ovf        = ovf_q;

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised successor to the single-purpose CPU performance counter: one cycle/instruction "total" counter with stall de-duplication, plus N_CH generic event counters. Each channel counts either level-high cycles or rising edges. Overflow is configurable as wrap or saturate. An atomic snapshot/shadow bank supports coherent readout through a registered select port. Sits beside the pipeline and is fed by stall enable, jump, branch-taken, load-use and similar single-bit event strobes.

Parameters:
N_CH, 3, number of event channels (1..16)
WIDTH, 32, width of every counter, shadow register and read data (8..64)
SAT, 0, 0 = counters wrap to 0 past max; 1 = counters hold at all-ones
EDGE_MASK, 0, N_CH-bit mask; bit i = 1 makes channel i count rising edges of in_EV[i], 0 counts every high cycle

Ports:
in_CLK  input  1  clock, all state updates on rising edge
in_RST  input  1  reset, synchronous, active-high
in_EN  input  1  pipeline enable; low = stalled
in_EV  input  N_CH  event strobes, bit i feeds channel i
in_CLR  input  1  synchronous clear of live counters, stall flag and overflow flags
in_FREEZE  input  1  hold all live counters
in_SNAP  input  1  copy live counters into shadow bank
in_SEL  input  5  readout select: 0 = total, k = channel k-1 (1..N_CH)
out_total  output  WIDTH  live total counter
out_ev  output  N_CH*WIDTH  live channel counters, channel i at bits [i*WIDTH +: WIDTH]
out_rd_data  output  WIDTH  shadow value chosen by in_SEL
out_snap_valid  output  1  one-cycle pulse, cycle after a snapshot
out_ovf  output  N_CH+1  sticky overflow flags; bit 0 = total, bit i+1 = channel i

Behaviour:
- One clock in_CLK; reset in_RST is synchronous and active-high.
- Reset: all live counters, shadow registers, out_rd_data, out_ovf, out_snap_valid, stall flag and edge-history registers = 0.
- Priority per cycle: in_RST > in_CLR > in_FREEZE > normal counting.
- Total counter (normal counting):
  - in_EN=1: +1, stall flag <= 0.
  - in_EN=0 and flag=0: +1, flag <= 1.
  - in_EN=0 and flag=1: hold.
  - Net effect: a stall run of any length adds exactly 1.
- Channel i (normal counting):
  - EDGE_MASK[i]=0: +1 each cycle in_EV[i]=1.
  - EDGE_MASK[i]=1: +1 when in_EV[i]=1 and the previous-cycle sample was 0.
  - Edge history: updates every cycle including freeze and clear; reset only by in_RST.
- Overflow (counter at 2^WIDTH-1 and an increment is due):
  - Counter becomes 0 (SAT=0) or stays at max (SAT=1).
  - The matching out_ovf bit sets the same edge and stays set until in_CLR or in_RST.
- in_CLR: live counters, flag and out_ovf <= 0 in one cycle. Shadow bank untouched.
- in_FREEZE: live counters, flag and out_ovf hold. Events during freeze are lost.
- in_SNAP:
  - Shadow <= live values as registered before this edge's update.
  - in_SNAP with in_CLR in the same cycle = atomic read-and-clear: shadow gets pre-clear values.
  - in_SNAP works during freeze.
  - out_snap_valid = 1 for exactly the cycle after each in_SNAP; back-to-back snaps give a continuous high.
- Readout:
  - out_rd_data registered, latency 1 cycle from in_SEL.
  - Selects the shadow value as of the same edge, so SNAP and SEL in one cycle return the new snapshot.
  - in_SEL > N_CH returns 0.
- out_total and out_ev are direct register outputs, no combinational path from inputs.

Test Plan:
- Reset, then in_EN=1 for 5 cycles, then in_EN=0 for 4 cycles, then in_EN=1 for 2 cycles -> out_total = 8; flag cleared after final enable.
- Default params, EDGE_MASK=3'b010; hold in_EV=3'b111 for 6 cycles then low -> ch0 = 6, ch1 = 1, ch2 = 6.
- WIDTH=8: drive ch0 for 257 cycles -> SAT=0: ch0 = 1, out_ovf[1] = 1. SAT=1: ch0 = 255, out_ovf[1] = 1. in_CLR -> ch0 = 0, out_ovf = 0.
- Counters at total=10, ch2=7; assert in_SNAP+in_CLR with in_SEL=3 -> next cycle: out_snap_valid = 1, out_rd_data = 7, live counters = 0. Then in_SEL=0 -> next cycle out_rd_data = 10.
- in_FREEZE for 4 cycles with in_EN=1 and in_EV=all-ones -> all counters unchanged. Release -> counting resumes next cycle. An edge-mode channel held high across the freeze gains no count.
- Mid-run in_RST with in_CLR and in_SNAP also high -> every output 0 the next cycle, including shadow readout and out_snap_valid. in_SEL=7 with N_CH=3 -> out_rd_data = 0.
